regfile_arbiter: RTL and testbench



---
 rtl/regfile_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Round-robin arbiter and sequencer between two datapath requesters and the
// 8-entry register file. One transaction is granted at a time. A granted
// transaction spends one cycle in ISSUE, where it drives the register file's
// single read or write port. Read data comes back to the owning requester two
// cycles after the handshake.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata   requester N transaction (N = 0, 1)
//   reqN_ready           combinational accept, high only in IDLE for the winner
//   rspN_valid/rdata     one-cycle read response pulse and held read data
//   rf_read_enable/addr  registered register-file read port
//   rf_write_enable/addr/data   registered register-file write port
//   rf_read_data         register-file read data (updated on the falling edge)
// -----------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic             req0_write,
  input  logic [2:0]       req0_addr,
  input  logic [width-1:0] req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [width-1:0] rsp0_rdata,

  input  logic             req1_valid,
  input  logic             req1_write,
  input  logic [2:0]       req1_addr,
  input  logic [width-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [width-1:0] rsp1_rdata,

  output logic             rf_read_enable,
  output logic             rf_write_enable,
  output logic [2:0]       rf_read_addr,
  output logic [2:0]       rf_write_addr,
  output logic [width-1:0] rf_write_data,
  input  logic [width-1:0] rf_read_data
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic               last_r;       // previous grant
  logic               has_grant_r;  // a grant has happened since reset
  logic               owner_r;      // requester owning the transaction in ISSUE
  logic               op_write_r;   // transaction in ISSUE is a write

  logic               any_valid_s;
  logic               winner_s;
  logic               xfer_s;
  logic               sel_write_s;
  logic [2:0]         sel_addr_s;
  logic [width-1:0]   sel_wdata_s;

  // Round-robin winner selection and mux of the winning request fields.
  // With no previous grant (just out of reset) a tie goes to requester 0,
  // so the alternation starts 0, 1, 0, 1 even though last resets to 0.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    winner_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      if (has_grant_r) begin
        winner_s = ~last_r;
      end else begin
        winner_s = 1'b0;
      end
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end

    if (winner_s) begin
      sel_write_s = req1_write;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_write_s = req0_write;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
  end

  // Next-state and ready generation. In IDLE any valid request is accepted
  // immediately (the winner always has valid set), so a transfer and the
  // move to ISSUE coincide.
  always_comb begin
    state_next_s = state_r;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    xfer_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_valid_s && !rst) begin
          req0_ready   = ~winner_s;
          req1_ready   = winner_s;
          xfer_s       = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Transaction latch, register-file port registers and read response capture.
  // The rf enables are loaded on the transfer edge so they are high exactly
  // for the ISSUE cycle; addresses and write data hold between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r          <= 1'b0;
      has_grant_r     <= 1'b0;
      owner_r         <= 1'b0;
      op_write_r      <= 1'b0;
      rf_read_enable  <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_read_addr    <= 3'd0;
      rf_write_addr   <= 3'd0;
      rf_write_data   <= {width{1'b0}};
      rsp0_valid      <= 1'b0;
      rsp1_valid      <= 1'b0;
      rsp0_rdata      <= {width{1'b0}};
      rsp1_rdata      <= {width{1'b0}};
    end else begin
      rf_read_enable  <= xfer_s & ~sel_write_s;
      rf_write_enable <= xfer_s & sel_write_s;
      rsp0_valid      <= 1'b0;
      rsp1_valid      <= 1'b0;

      if (xfer_s) begin
        owner_r     <= winner_s;
        op_write_r  <= sel_write_s;
        last_r      <= winner_s;
        has_grant_r <= 1'b1;
        if (sel_write_s) begin
          rf_write_addr <= sel_addr_s;
          rf_write_data <= sel_wdata_s;
        end else begin
          rf_read_addr  <= sel_addr_s;
        end
      end

      // rf_read_data was refreshed on the falling edge inside ISSUE.
      if ((state_r == ISSUE) && !op_write_r) begin
        if (owner_r) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= rf_read_data;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= rf_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Directed bench for regfile_arbiter: a cycle-by-cycle vector table for the
// single-requester, cross-requester and ready-gating cases, followed by
// hand-written sequences for contention, reset during a read and a full
// write/read sweep. Includes a small behavioural register file model.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [2:0]  req0_addr;
  logic [15:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [2:0]  req1_addr;
  logic [15:0] req1_wdata, rsp1_rdata;
  logic        rf_read_enable, rf_write_enable;
  logic [2:0]  rf_read_addr, rf_write_addr;
  logic [15:0] rf_write_data, rf_read_data;

  int tests;
  int fails;
  int overlap_cnt;
  logic preload_en;
  logic [15:0] rf_mem [8];

  regfile_arbiter #(.width(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_write     (req0_write),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_ready     (req0_ready),
    .rsp0_valid     (rsp0_valid),
    .rsp0_rdata     (rsp0_rdata),
    .req1_valid     (req1_valid),
    .req1_write     (req1_write),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_ready     (req1_ready),
    .rsp1_valid     (rsp1_valid),
    .rsp1_rdata     (rsp1_rdata),
    .rf_read_enable (rf_read_enable),
    .rf_write_enable(rf_write_enable),
    .rf_read_addr   (rf_read_addr),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_read_data   (rf_read_data)
  );

  always #5 clk = ~clk;

  // Register file model: commits writes on the rising edge, updates read data
  // on the falling edge while read enable is high.
  always @(posedge clk) begin
    if (rf_write_enable) begin
      rf_mem[rf_write_addr] <= rf_write_data;
    end else if (preload_en) begin
      rf_mem[2] <= 16'h00AA;
      rf_mem[3] <= 16'h00BB;
    end
  end

  always @(negedge clk) begin
    if (rf_read_enable) rf_read_data <= rf_mem[rf_read_addr];
    if (rf_read_enable && rf_write_enable) overlap_cnt = overlap_cnt + 1;
  end

  typedef struct {
    logic        v0, w0; logic [2:0] a0; logic [15:0] d0;
    logic        v1, w1; logic [2:0] a1; logic [15:0] d1;
    logic        e_rdy0, e_rdy1, e_we, e_re; logic [2:0] e_addr;
    logic        e_rv0; logic [15:0] e_rd0;
    logic        e_rv1; logic [15:0] e_rd1;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 3'd0; req0_wdata = 16'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 3'd0; req1_wdata = 16'h0;
  endtask

  // One complete transaction on requester r; d is the write data or the
  // expected read data.
  task automatic run_txn(input logic r, input logic wr, input logic [2:0] a,
                         input logic [15:0] d, input string tag);
    logic got;
    got = 1'b0;
    clear_reqs();
    if (r) begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = wr ? d : 16'h0;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = wr ? d : 16'h0;
    end
    for (int n = 0; n < 4 && !got; n++) begin
      #1;
      if ((r ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({tag, " granted"}, 32'(got), 32'd1);
    if (got) begin
      @(posedge clk); #1;
      clear_reqs();
      if (wr) begin
        check({tag, " we"},    32'(rf_write_enable), 32'd1);
        check({tag, " waddr"}, 32'(rf_write_addr),   32'(a));
        check({tag, " wdata"}, 32'(rf_write_data),   32'(d));
      end else begin
        check({tag, " re"},    32'(rf_read_enable),  32'd1);
        check({tag, " raddr"}, 32'(rf_read_addr),    32'(a));
      end
      @(posedge clk); #1;
      if (!wr) begin
        check({tag, " own rsp_valid"}, 32'(r ? rsp1_valid : rsp0_valid), 32'd1);
        check({tag, " rdata"},         32'(r ? rsp1_rdata : rsp0_rdata), 32'(d));
      end
      check({tag, " other rsp_valid"}, 32'(r ? rsp0_valid : rsp1_valid), 32'd0);
    end else begin
      clear_reqs();
    end
  endtask

  initial begin
    tests = 0; fails = 0; overlap_cnt = 0;
    clk = 1'b0; rst = 1'b1; preload_en = 1'b1;
    clear_reqs();
    // Valid requests during reset must not be accepted.
    req0_valid = 1'b1; req1_valid = 1'b1;

    //          v0 w0 a0    d0        v1 w1 a1    d1        r0 r1 we re addr  rv0 rd0        rv1 rd1
    vecs[0]  = '{1'b1,1'b1,3'd5,16'h1234, 1'b0,1'b0,3'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0,3'd0, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[1]  = '{1'b1,1'b0,3'd5,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,3'd5, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[2]  = '{1'b1,1'b0,3'd5,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0,3'd0, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[3]  = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b1,3'd5, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[4]  = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,3'd0, 1'b1,16'h1234, 1'b0,16'h0000};
    vecs[5]  = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,3'd0, 1'b0,16'h1234, 1'b0,16'h0000};
    vecs[6]  = '{1'b0,1'b0,3'd0,16'h0000, 1'b1,1'b1,3'd7,16'hBEEF, 1'b0,1'b1,1'b0,1'b0,3'd0, 1'b0,16'h1234, 1'b0,16'h0000};
    vecs[7]  = '{1'b1,1'b0,3'd7,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,3'd7, 1'b0,16'h1234, 1'b0,16'h0000};
    vecs[8]  = '{1'b1,1'b0,3'd7,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0,3'd0, 1'b0,16'h1234, 1'b0,16'h0000};
    vecs[9]  = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b1,3'd7, 1'b0,16'h1234, 1'b0,16'h0000};
    vecs[10] = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,3'd0, 1'b1,16'hBEEF, 1'b0,16'h0000};
    vecs[11] = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,3'd0, 1'b0,16'hBEEF, 1'b0,16'h0000};
    vecs[12] = '{1'b1,1'b0,3'd2,16'h0000, 1'b1,1'b0,3'd3,16'h0000, 1'b0,1'b1,1'b0,1'b0,3'd0, 1'b0,16'hBEEF, 1'b0,16'h0000};
    vecs[13] = '{1'b1,1'b0,3'd2,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b1,3'd3, 1'b0,16'hBEEF, 1'b0,16'h0000};
    vecs[14] = '{1'b1,1'b0,3'd2,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0,3'd0, 1'b0,16'hBEEF, 1'b1,16'h00BB};
    vecs[15] = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b1,3'd2, 1'b0,16'hBEEF, 1'b0,16'h00BB};
    vecs[16] = '{1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,3'd0, 1'b1,16'h00AA, 1'b0,16'h00BB};

    repeat (2) @(posedge clk);
    #1;
    check("reset ready0", 32'(req0_ready), 32'd0);
    check("reset ready1", 32'(req1_ready), 32'd0);
    check("reset rf enables", 32'({rf_read_enable, rf_write_enable}), 32'd0);
    check("reset rf addrs", 32'({rf_read_addr, rf_write_addr}), 32'd0);
    check("reset rf wdata", 32'(rf_write_data), 32'd0);
    check("reset rsp valids", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("reset rsp data", {rsp0_rdata, rsp1_rdata}, 32'd0);

    preload_en = 1'b0;
    rst = 1'b0;

    // Vector table: write/read on requester 0, cross-requester visibility,
    // ready gating during ISSUE, tie after a requester-0 grant.
    for (int i = 0; i < 17; i++) begin
      req0_valid = vecs[i].v0; req0_write = vecs[i].w0; req0_addr = vecs[i].a0; req0_wdata = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_write = vecs[i].w1; req1_addr = vecs[i].a1; req1_wdata = vecs[i].d1;
      #1;
      check($sformatf("vec%0d ready0", i), 32'(req0_ready), 32'(vecs[i].e_rdy0));
      check($sformatf("vec%0d ready1", i), 32'(req1_ready), 32'(vecs[i].e_rdy1));
      check($sformatf("vec%0d rf_we", i), 32'(rf_write_enable), 32'(vecs[i].e_we));
      check($sformatf("vec%0d rf_re", i), 32'(rf_read_enable), 32'(vecs[i].e_re));
      if (vecs[i].e_we) check($sformatf("vec%0d waddr", i), 32'(rf_write_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_re) check($sformatf("vec%0d raddr", i), 32'(rf_read_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].e_rv0));
      check($sformatf("vec%0d rsp0_rdata", i), 32'(rsp0_rdata), 32'(vecs[i].e_rd0));
      check($sformatf("vec%0d rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].e_rv1));
      check($sformatf("vec%0d rsp1_rdata", i), 32'(rsp1_rdata), 32'(vecs[i].e_rd1));
      @(posedge clk); #1;
    end

    // Contention from a fresh reset: grants 0,1,0,1 every 2 cycles, responses
    // two cycles after each grant.
    clear_reqs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd2;
    req1_valid = 1'b1; req1_addr = 3'd3;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("cont%0d ready0", k), 32'(req0_ready), 32'((k % 4) == 0));
      check($sformatf("cont%0d ready1", k), 32'(req1_ready), 32'((k % 4) == 2));
      check($sformatf("cont%0d rsp0_valid", k), 32'(rsp0_valid), 32'((k >= 2) && ((k % 4) == 2)));
      check($sformatf("cont%0d rsp1_valid", k), 32'(rsp1_valid), 32'((k >= 4) && ((k % 4) == 0)));
      if ((k >= 2) && ((k % 4) == 2)) check($sformatf("cont%0d rsp0_rdata", k), 32'(rsp0_rdata), 32'h00AA);
      if ((k >= 4) && ((k % 4) == 0)) check($sformatf("cont%0d rsp1_rdata", k), 32'(rsp1_rdata), 32'h00BB);
      @(posedge clk); #1;
    end

    // Now in ISSUE of a requester-0 read: reset aborts it.
    check("abort in issue re", 32'(rf_read_enable), 32'd1);
    rst = 1'b1;
    #1;
    check("rst-in-issue ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    check("abort re", 32'(rf_read_enable), 32'd0);
    check("abort raddr", 32'(rf_read_addr), 32'd0);
    check("abort rsp valids", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("abort rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    check("abort ready in rst", 32'({req0_ready, req1_ready}), 32'd0);
    rst = 1'b0;
    #1;
    check("post-reset tie ready0", 32'(req0_ready), 32'd1);
    check("post-reset tie ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    clear_reqs();
    check("post-reset no stray rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(posedge clk); #1;
    check("post-reset rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("post-reset rsp0_rdata", 32'(rsp0_rdata), 32'h00AA);
    @(posedge clk); #1;

    // Full sweep: alternating-requester writes, then reads from the other side.
    for (int i = 0; i < 8; i++)
      run_txn(1'(i % 2), 1'b1, 3'(i), 16'h1000 + 16'(i), $sformatf("sweep wr%0d", i));
    for (int i = 0; i < 8; i++)
      run_txn(1'((i + 1) % 2), 1'b0, 3'(i), 16'h1000 + 16'(i), $sformatf("sweep rd%0d", i));

    check("rf enables never both high", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
